// File: rtl/key_matrix_scanner.sv
// 4x4 active-low key matrix scanner with per-tick debounce and a one-deep
// acknowledged event register with sticky overrun.
module key_matrix_scanner #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int unsigned TickW = $clog2(SCAN_DIV);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TickW-1:0] TickMax = TickW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CNT);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  logic [3:0]       col_meta_q, col_s_q;
  logic [TickW-1:0] tick_cnt_q;
  state_e           state_q;
  logic [1:0]       row_idx_q, cand_row_q, cand_col_q;
  logic [3:0]       row_q;
  logic [CntW-1:0]  stable_cnt_q;
  logic             key_held_q, key_valid_q, overrun_q;
  logic [3:0]       key_code_q;

  logic             tick;
  logic [1:0]       first_low;
  logic             cand_low;
  logic [CntW-1:0]  stable_inc;
  logic [1:0]       row_inc;
  logic [3:0]       row_inc_drive;
  logic             press_evt;
  logic [3:0]       evt_code;

  assign tick          = (tick_cnt_q == TickMax);
  assign cand_low      = ~col_s_q[cand_col_q];
  assign stable_inc    = stable_cnt_q + CntOne;
  assign row_inc       = row_idx_q + 2'd1;
  assign row_inc_drive = ~(4'b0001 << row_inc);

  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) first_low = 2'(i);
    end
  end

  // A press is accepted either straight from SCAN (single-tick debounce) or from DEBOUNCE.
  always_comb begin
    press_evt = 1'b0;
    evt_code  = {cand_row_q, cand_col_q};
    if (tick) begin
      if (state_q == StScan) begin
        press_evt = (col_s_q != 4'hF) && (DEBOUNCE_CNT == 1);
        evt_code  = {row_idx_q, first_low};
      end else if (state_q == StDebounce) begin
        press_evt = cand_low && (stable_inc == CntMax);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      tick_cnt_q <= '0;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StScan;
      row_idx_q    <= 2'd0;
      row_q        <= 4'b1110;
      cand_row_q   <= 2'd0;
      cand_col_q   <= 2'd0;
      stable_cnt_q <= '0;
      key_held_q   <= 1'b0;
    end else if (tick) begin
      unique case (state_q)
        StScan: begin
          if (col_s_q == 4'hF) begin
            row_idx_q <= row_inc;
            row_q     <= row_inc_drive;
          end else begin
            cand_row_q   <= row_idx_q;
            cand_col_q   <= first_low;
            stable_cnt_q <= CntOne;
            if (press_evt) begin
              state_q    <= StHeld;
              key_held_q <= 1'b1;
            end else begin
              state_q <= StDebounce;
            end
          end
        end
        StDebounce: begin
          if (cand_low) begin
            stable_cnt_q <= stable_inc;
            if (press_evt) begin
              state_q    <= StHeld;
              key_held_q <= 1'b1;
            end
          end else begin
            state_q      <= StScan;
            stable_cnt_q <= '0;
            row_idx_q    <= row_inc;
            row_q        <= row_inc_drive;
          end
        end
        StHeld: begin
          if (!cand_low) begin
            if (CntOne == CntMax) begin
              state_q      <= StScan;
              key_held_q   <= 1'b0;
              stable_cnt_q <= '0;
              row_idx_q    <= row_inc;
              row_q        <= row_inc_drive;
            end else begin
              state_q      <= StRelease;
              stable_cnt_q <= CntOne;
            end
          end
        end
        StRelease: begin
          if (cand_low) begin
            state_q      <= StHeld;
            stable_cnt_q <= '0;
          end else if (stable_inc == CntMax) begin
            state_q      <= StScan;
            key_held_q   <= 1'b0;
            stable_cnt_q <= '0;
            row_idx_q    <= row_inc;
            row_q        <= row_inc_drive;
          end else begin
            stable_cnt_q <= stable_inc;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  // A simultaneous ack frees the slot for the new event; otherwise an event on a full slot is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (press_evt && (!key_valid_q || key_ack)) begin
      key_code_q  <= evt_code;
      key_valid_q <= 1'b1;
    end else if (press_evt) begin
      overrun_q <= 1'b1;
    end else if (key_ack) begin
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Self-checking bench: a key-matrix model drives col from row; expected codes go through a queue.
module tb_key_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_ack, key_held, overrun;
  logic [15:0] pressed;

  always #5 clk = ~clk;

  // Pressed key (r,c) shorts row r to column c.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  key_matrix_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_held (key_held),
    .overrun  (overrun)
  );

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
    int         hold;
  } vec_t;

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         n_events = 0;
  logic       valid_prev = 1'b0;
  logic [3:0] exp_q[$];
  vec_t       vecs[5];

  always @(negedge clk) begin
    if (key_valid && !valid_prev) n_events <= n_events + 1;
    valid_prev <= key_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got key_code %0h, expected no event", name, key_code);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(key_code), 32'(e));
    end
  endtask

  // sel 0: key_valid, 1: key_held, 2: row[idx]
  task automatic wait_sig(input int sel, input int idx, input logic lvl, output bit ok);
    logic v;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      v = (sel == 0) ? key_valid : (sel == 1) ? key_held : row[idx];
      if (v == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_once();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic release_key(input int r, input int c);
    bit ok;
    pressed[r*4+c] = 1'b0;
    wait_sig(1, 0, 1'b0, ok);
    check("release_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int ev0;
    ev0 = n_events;
    exp_q.push_back(v.code);
    pressed[v.r*4+v.c] = 1'b1;
    wait_sig(0, 0, 1'b1, ok);
    check("press_timeout", 32'(ok), 32'd1);
    sb_compare("press_code");
    check("press_held", 32'(key_held), 32'd1);
    repeat (v.hold) @(negedge clk);
    @(negedge clk);
    check("single_event", 32'(n_events), 32'(ev0 + 1));
    check("no_overrun", 32'(overrun), 32'd0);
    check("valid_kept", 32'(key_valid), 32'd1);
    ack_once();
    check("ack_clears_valid", 32'(key_valid), 32'd0);
    release_key(v.r, v.c);
  endtask

  initial begin
    bit ok;
    int ev0;
    vecs[0] = '{2, 1, 4'h9, 80};
    vecs[1] = '{0, 0, 4'h0, 0};
    vecs[2] = '{3, 2, 4'hE, 0};
    vecs[3] = '{1, 3, 4'h7, 0};
    vecs[4] = '{0, 3, 4'h3, 0};

    rst     = 1'b1;
    key_ack = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_row", 32'(row), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Idle scan: one row step every 4 clocks.
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      check("idle_row", 32'(row), 32'(exp_row));
    end
    check("idle_valid", 32'(key_valid), 32'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Bounce: alternating 4-cycle windows never give 3 consecutive low ticks.
    ev0 = n_events;
    for (int k = 0; k < 12; k++) begin
      pressed[1*4+3] = (k % 2 == 0);
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    check("bounce_no_event", 32'(n_events), 32'(ev0));
    check("bounce_no_valid", 32'(key_valid), 32'd0);
    exp_q.push_back(4'h7);
    pressed[1*4+3] = 1'b1;
    wait_sig(0, 0, 1'b1, ok);
    check("bounce_timeout", 32'(ok), 32'd1);
    sb_compare("bounce_code");
    repeat (20) @(negedge clk);
    check("bounce_one_event", 32'(n_events), 32'(ev0 + 1));
    ack_once();
    release_key(1, 3);

    // Overrun: second press while first is unacknowledged.
    exp_q.push_back(4'h1);
    pressed[0*4+1] = 1'b1;
    wait_sig(0, 0, 1'b1, ok);
    check("ovr_first_timeout", 32'(ok), 32'd1);
    sb_compare("ovr_first_code");
    release_key(0, 1);
    check("ovr_not_yet", 32'(overrun), 32'd0);
    pressed[3*4+3] = 1'b1;
    wait_sig(1, 0, 1'b1, ok);
    check("ovr_second_timeout", 32'(ok), 32'd1);
    check("ovr_code_kept", 32'(key_code), 32'h1);
    check("ovr_flag", 32'(overrun), 32'd1);
    release_key(3, 3);
    check("ovr_sticky", 32'(overrun), 32'd1);
    ack_once();
    check("ovr_ack_valid", 32'(key_valid), 32'd0);
    check("ovr_ack_clear", 32'(overrun), 32'd0);

    // Ack coincident with the next press event (third tick after the row becomes active).
    exp_q.push_back(4'hA);
    pressed[2*4+2] = 1'b1;
    wait_sig(0, 0, 1'b1, ok);
    check("coin_first_timeout", 32'(ok), 32'd1);
    sb_compare("coin_first_code");
    release_key(2, 2);
    wait_sig(2, 1, 1'b1, ok);
    check("coin_row_off_timeout", 32'(ok), 32'd1);
    exp_q.push_back(4'h4);
    pressed[1*4+0] = 1'b1;
    wait_sig(2, 1, 1'b0, ok);
    check("coin_row_on_timeout", 32'(ok), 32'd1);
    repeat (11) @(negedge clk);
    check("coin_not_early", 32'(key_held), 32'd0);
    ack_once();
    check("coin_valid", 32'(key_valid), 32'd1);
    sb_compare("coin_code");
    check("coin_overrun", 32'(overrun), 32'd0);
    check("coin_held", 32'(key_held), 32'd1);
    ack_once();
    release_key(1, 0);

    // Asynchronous reset during HELD.
    exp_q.push_back(4'hB);
    pressed[2*4+3] = 1'b1;
    wait_sig(1, 0, 1'b1, ok);
    check("hold_timeout", 32'(ok), 32'd1);
    sb_compare("hold_code");
    #2 rst = 1'b1;
    #1;
    check("arst_row", 32'(row), 32'hE);
    check("arst_code", 32'(key_code), 32'h0);
    check("arst_valid", 32'(key_valid), 32'd0);
    check("arst_held", 32'(key_held), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    pressed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rescan_row0", 32'(row), 32'hE);
    repeat (4) @(negedge clk);
    check("rescan_row1", 32'(row), 32'hD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per scan tick (1 ms at 100 MHz); legal range 2 or more.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20, consecutive stable ticks needed to accept a press or release; legal range 1 or more.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port row, output, 4, active-low row drive; exactly one bit low at all times.
REQ-006 SHALL have port col, input, 4, active-low column sense (externally pulled up), asynchronous to clk.
REQ-007 SHALL have port key_code, output, 4, accepted key = {row_idx[1:0], col_idx[1:0]}.
REQ-008 SHALL have port key_valid, output, 1, key_code holds an unacknowledged event.
REQ-009 SHALL have port key_ack, input, 1, consumer acknowledge, sampled on posedge.
REQ-010 SHALL have port key_held, output, 1, high while an accepted key has not yet been debounced as released.
REQ-011 SHALL have port overrun, output, 1, sticky flag set when an event is dropped.

Function
REQ-012 SHALL pass col through a 2-flop synchronizer; all decisions use the synchronized value colS.
REQ-013 SHALL count tick_cnt 0..SCAN_DIV-1 with wrap; tick is high for the one cycle where tick_cnt==SCAN_DIV-1.
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE and evaluate transitions only on tick cycles.
REQ-015 SCAN: if colS is all ones, row_idx SHALL increment mod 4 and row SHALL update in the following cycle; otherwise latch cand_row=row_idx, cand_col=lowest index with colS bit 0, set stable_cnt=1, and go to DEBOUNCE without advancing the row.
REQ-016 DEBOUNCE: if colS[cand_col]==0, stable_cnt SHALL increment; otherwise go to SCAN with row_idx incremented.
REQ-017 On reaching stable_cnt==DEBOUNCE_CNT, the FSM SHALL go to HELD and raise the press event for one cycle; with DEBOUNCE_CNT=1 the event SHALL fire on the SCAN tick that detects the key.
REQ-018 HELD: key_held SHALL be 1; when colS[cand_col]==1, go to RELEASE with stable_cnt=1.
REQ-019 RELEASE: if colS[cand_col]==1, stable_cnt SHALL increment; if it returns to 0, go to HELD; at DEBOUNCE_CNT, go to SCAN with key_held=0 and row_idx incremented.
REQ-020 Additional keys pressed while in DEBOUNCE, HELD or RELEASE SHALL be ignored.
REQ-021 On a press event with key_valid==0, key_code SHALL be loaded with {cand_row,cand_col} and key_valid set in the next cycle.
REQ-022 key_valid SHALL clear on the cycle after key_ack is sampled high; key_ack with key_valid==0 SHALL have no effect.
REQ-023 On a press event with key_valid==1 and key_ack==1 in the same cycle, the new code SHALL load, key_valid SHALL stay 1, and overrun SHALL stay unchanged.
REQ-024 On a press event with key_valid==1 and key_ack==0, key_code SHALL be retained, the event dropped, and overrun set to 1.
REQ-025 overrun SHALL clear only on key_ack or reset.

Reset
REQ-026 While rst is high, the outputs SHALL be row=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, with FSM=SCAN, tick_cnt=0, stable_cnt=0, and synchronizer flops at 4'b1111.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort immediately; after release, scanning SHALL restart at row 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-028 Idle, col=4'hF: row cycles 1110, 1101, 1011, 0111, advancing every 4 clk; key_valid stays 0.
REQ-029 Press row 2/col 1 held for 20 ticks, key_ack held 0: key_code=4'h9, key_valid=1 and stays 1, key_held=1, no second event.
REQ-030 Press row 1/col 3 bouncing (low 1 tick, high 1 tick) then stable: no event during the bounce; exactly one event with key_code=4'h7 after 3 stable ticks.
REQ-031 Two presses with no ack between them: first code retained and overrun=1; key_ack then gives key_valid=0 and overrun=0 the next cycle.
REQ-032 key_ack coincident with the second press event: key_valid stays 1, key_code updates to the new key, overrun=0.
REQ-033 rst pulsed during HELD: outputs return to reset values asynchronously; rescan starts at row=1110.
